// File: rtl/pad_window5x5_pkg.sv
// ---------------------------------------------------------------------------
// pad_window5x5_pkg
//
// Shared definitions for the conv1 window builder of the LeNet-5 pipeline.
//   - CLOG2        : ceiling log2, never narrower than one bit, used to size
//                    the row/column counters and the window index outputs
//   - LENET_*      : geometry of the zero-padded LeNet input frame
//   - PIX_W        : width of one pixel
//   - err_flags_t  : the three sticky framing error flags kept together
// ---------------------------------------------------------------------------
package pad_window5x5_pkg;

    localparam int LENET_W   = 32;
    localparam int LENET_H   = 32;
    localparam int LENET_K   = 5;
    localparam int LENET_PAD = 4;

    localparam int PIX_W = 8;

    // Sticky framing errors, one bit per kind of framing violation.
    typedef struct packed {
        logic line;
        logic frame;
        logic pad;
    } err_flags_t;

    // Ceiling log2 of value. A one-bit result is returned for values of 0, 1
    // and 2 so that every counter built from it has a legal width.
    function automatic int CLOG2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pad_window5x5_line_store.sv
// ---------------------------------------------------------------------------
// line_store_k
//
// Column-addressed store of the K-1 most recent lines. Each address holds
// the K-1 bytes of one column, entry 0 being the oldest (top) line. The read
// port is combinational, so a read and a write to the same column in one
// cycle return the old contents (read-before-write).
//
// Ports
//   clk        : rising-edge clock
//   addr_i     : column being accessed
//   we_i       : write enable for the column at addr_i
//   wr_data_i  : new K-1 entries for the column
//   rd_data_o  : current K-1 entries of the column at addr_i
// ---------------------------------------------------------------------------
module line_store_k
    import pad_window5x5_pkg::*;
#(
    parameter int W  = LENET_W,
    parameter int K  = LENET_K,
    parameter int AW = CLOG2(W)
) (
    input  logic                      clk,
    input  logic [AW-1:0]             addr_i,
    input  logic                      we_i,
    input  logic [PIX_W*(K-1)-1:0]    wr_data_i,
    output logic [PIX_W*(K-1)-1:0]    rd_data_o
);

    logic [PIX_W*(K-1)-1:0] mem_q [W];

    // The old column contents are presented for the whole cycle in which the
    // column is overwritten, which is what lets the window builder read and
    // update the same column on one accepted pixel.
    assign rd_data_o = mem_q[addr_i];

    // No reset: a column is always refilled with K-1 fresh lines before any
    // window that depends on it can be emitted.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/pad_window5x5.sv
// ---------------------------------------------------------------------------
// pad_window5x5
//
// Turns the zero-padded W x H pixel stream into KxK windows for the conv1
// MAC array and checks the framing of the incoming stream.
//
// Ports
//   clk            : rising-edge clock
//   srst           : asynchronous active-high reset
//   in_valid       : one-cycle pixel strobe, may be back-to-back
//   in_pixel       : pixel value
//   in_line_last   : marks the last pixel of a line
//   in_frame_last  : marks the last pixel of a frame
//   in_is_pad      : pixel belongs to a pad line
//   win_valid      : one-cycle window strobe, one cycle after the pixel
//   win_data       : window, element (r,c) at bits [8*(r*K+c) +: 8]
//   win_row        : output row index 0..H-K
//   win_col        : output column index 0..W-K
//   win_last       : last window of the frame
//   err_line       : sticky line-length error
//   err_frame      : sticky frame-length error
//   err_pad        : sticky pad-flag error
// ---------------------------------------------------------------------------
module pad_window5x5
    import pad_window5x5_pkg::*;
#(
    parameter int W   = LENET_W,
    parameter int H   = LENET_H,
    parameter int K   = LENET_K,
    parameter int PAD = LENET_PAD
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      in_valid,
    input  logic [PIX_W-1:0]          in_pixel,
    input  logic                      in_line_last,
    input  logic                      in_frame_last,
    input  logic                      in_is_pad,
    output logic                      win_valid,
    output logic [PIX_W*K*K-1:0]      win_data,
    output logic [CLOG2(H)-1:0]       win_row,
    output logic [CLOG2(W)-1:0]       win_col,
    output logic                      win_last,
    output logic                      err_line,
    output logic                      err_frame,
    output logic                      err_pad
);

    localparam int CW = CLOG2(W);
    localparam int RW = CLOG2(H);

    localparam logic [CW-1:0] COL_LAST      = CW'(W - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(H - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);
    localparam logic [RW-1:0] PAD_TOP_END   = RW'(PAD);
    localparam logic [RW-1:0] PAD_BOT_START = RW'(H - PAD);

    logic [CW-1:0]              col_q;
    logic [CW-1:0]              col_d;
    logic [RW-1:0]              row_q;
    logic [RW-1:0]              row_d;
    err_flags_t                 err_q;
    err_flags_t                 err_d;

    logic [PIX_W*(K-1)-1:0]     ls_rd;
    logic [PIX_W*(K-1)-1:0]     ls_wr;
    logic [PIX_W-1:0]           column [K];
    logic [PIX_W-1:0]           shift_q [K][K];
    logic [PIX_W-1:0]           shift_d [K][K];
    logic [PIX_W*K*K-1:0]       win_flat_d;

    logic                       at_col_end;
    logic                       at_frame_end;
    logic                       pad_expected;
    logic                       emit;

    logic                       win_valid_q;
    logic                       win_last_q;
    logic [PIX_W*K*K-1:0]       win_data_q;
    logic [RW-1:0]              win_row_q;
    logic [CW-1:0]              win_col_q;

    line_store_k #(
        .W  (W),
        .K  (K),
        .AW (CW)
    ) u_line_store (
        .clk       (clk),
        .addr_i    (col_q),
        .we_i      (in_valid),
        .wr_data_i (ls_wr),
        .rd_data_o (ls_rd)
    );

    // Build the K-deep column for the current pixel: the K-1 stored lines on
    // top, the new pixel at the bottom. The column written back drops the
    // oldest entry so the store always holds the latest K-1 lines.
    always_comb begin
        ls_wr = '0;
        for (int e = 0; e < K - 1; e++) begin
            column[e] = ls_rd[PIX_W*e +: PIX_W];
        end
        column[K-1] = in_pixel;
        for (int e = 0; e < K - 1; e++) begin
            ls_wr[PIX_W*e +: PIX_W] = column[e+1];
        end
    end

    // The new column enters the window from the right and every row moves one
    // place left. The flattened form of the shifted window is what gets
    // captured into the output register when a window is emitted.
    always_comb begin
        win_flat_d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                shift_d[r][c] = shift_q[r][c+1];
            end
            shift_d[r][K-1] = column[r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat_d[PIX_W*(r*K+c) +: PIX_W] = shift_d[r][c];
            end
        end
    end

    // Position tracking and framing checks. A line ends either on the flag or
    // on reaching the last column, so a bad line length resyncs the counters
    // instead of drifting. The frame flag always returns to (0,0). Each error
    // kind is a mismatch between what the flag says and where the counters
    // are, accumulated into the sticky flags.
    always_comb begin
        at_col_end   = (col_q == COL_LAST);
        at_frame_end = at_col_end && (row_q == ROW_LAST);
        pad_expected = (row_q < PAD_TOP_END) || (row_q >= PAD_BOT_START);
        emit         = in_valid && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);

        col_d = col_q;
        row_d = row_q;
        err_d = err_q;
        if (in_valid) begin
            if (in_frame_last) begin
                col_d = '0;
                row_d = '0;
            end else if (in_line_last || at_col_end) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            err_d.line  = err_q.line  | (in_line_last  ^ at_col_end);
            err_d.frame = err_q.frame | (in_frame_last ^ at_frame_end);
            err_d.pad   = err_q.pad   | (in_is_pad     ^ pad_expected);
        end
    end

    // The working window shifts on every accepted pixel and needs no reset,
    // since it is completely refilled before the first column that emits.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            shift_q <= shift_d;
        end
    end

    // Counters, sticky errors and the registered window outputs. The window
    // payload only loads on an emitted window so it holds between strobes.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            col_q       <= '0;
            row_q       <= '0;
            err_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            win_valid_q <= emit;
            win_last_q  <= emit && at_frame_end;
            if (emit) begin
                win_data_q <= win_flat_d;
                win_row_q  <= row_q - ROW_FIRST_WIN;
                win_col_q  <= col_q - COL_FIRST_WIN;
            end
            if (in_valid) begin
                col_q <= col_d;
                row_q <= row_d;
                err_q <= err_d;
            end
        end
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_data  = win_data_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign err_line  = err_q.line;
    assign err_frame = err_q.frame;
    assign err_pad   = err_q.pad;

endmodule

// File: tb/tb_pad_window5x5.sv
// ---------------------------------------------------------------------------
// tb_pad_window5x5
//
// Directed bench for pad_window5x5. Ramp frames are streamed through the
// block while a small reference of the column history, counters and sticky
// flags predicts every output each cycle. A table of hand-computed window
// elements and hand-written framing sequences cover the corner cases.
// ---------------------------------------------------------------------------
module tb_pad_window5x5;
    import pad_window5x5_pkg::*;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int K    = 5;
    localparam int PAD  = 4;
    localparam int NW   = W - K + 1;
    localparam int NWIN = (H - K + 1) * (W - K + 1);
    localparam int DW   = 8 * K * K;
    localparam int OW   = DW + 15;

    logic           clk = 1'b0;
    logic           srst;
    logic           in_valid;
    logic [7:0]     in_pixel;
    logic           in_line_last;
    logic           in_frame_last;
    logic           in_is_pad;
    logic           win_valid;
    logic [DW-1:0]  win_data;
    logic [4:0]     win_row;
    logic [4:0]     win_col;
    logic           win_last;
    logic           err_line;
    logic           err_frame;
    logic           err_pad;

    int checks = 0;
    int errors = 0;

    // Reference state
    int             mRow;
    int             mCol;
    logic [7:0]     colHist [W][K];
    logic           mValid;
    logic           mLast;
    logic [4:0]     mWr;
    logic [4:0]     mWc;
    logic [DW-1:0]  mData;
    logic           mErrLine;
    logic           mErrFrame;
    logic           mErrPad;

    // Observed windows
    int             winCount;
    logic           capture;
    logic [DW-1:0]  capData [NWIN];
    logic           capLast [NWIN];

    typedef struct {
        int         wr;
        int         wc;
        int         elem;
        logic [7:0] data;
        logic       last;
    } spot_t;

    spot_t spots [9];

    pad_window5x5 #(
        .W   (W),
        .H   (H),
        .K   (K),
        .PAD (PAD)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .in_valid      (in_valid),
        .in_pixel      (in_pixel),
        .in_line_last  (in_line_last),
        .in_frame_last (in_frame_last),
        .in_is_pad     (in_is_pad),
        .win_valid     (win_valid),
        .win_data      (win_data),
        .win_row       (win_row),
        .win_col       (win_col),
        .win_last      (win_last),
        .err_line      (err_line),
        .err_frame     (err_frame),
        .err_pad       (err_pad)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rampPix(input int r, input int c);
        return 8'((r * 32 + c) & 255);
    endfunction

    function automatic logic padOf(input int r);
        return (r < PAD) || (r >= H - PAD);
    endfunction

    task automatic modelReset();
        mRow      = 0;
        mCol      = 0;
        mValid    = 1'b0;
        mLast     = 1'b0;
        mWr       = '0;
        mWc       = '0;
        mData     = '0;
        mErrLine  = 1'b0;
        mErrFrame = 1'b0;
        mErrPad   = 1'b0;
    endtask

    // Predict the outputs that follow the inputs currently on the pins.
    task automatic modelStep();
        int r;
        int c;
        mValid = 1'b0;
        mLast  = 1'b0;
        if (in_valid) begin
            r = mRow;
            c = mCol;
            for (int e = 0; e < K - 1; e++) begin
                colHist[c][e] = colHist[c][e+1];
            end
            colHist[c][K-1] = in_pixel;
            if (r >= K - 1 && c >= K - 1) begin
                mValid = 1'b1;
                mLast  = (r == H - 1) && (c == W - 1);
                mWr    = 5'(r - (K - 1));
                mWc    = 5'(c - (K - 1));
                for (int rr = 0; rr < K; rr++) begin
                    for (int cc = 0; cc < K; cc++) begin
                        mData[8*(rr*K+cc) +: 8] = colHist[c-(K-1)+cc][rr];
                    end
                end
            end
            if (in_line_last != (c == W - 1)) mErrLine = 1'b1;
            if (in_frame_last != ((r == H - 1) && (c == W - 1))) mErrFrame = 1'b1;
            if (in_is_pad != padOf(r)) mErrPad = 1'b1;
            if (in_frame_last) begin
                mRow = 0;
                mCol = 0;
            end else if (in_line_last || c == W - 1) begin
                mCol = 0;
                mRow = (r == H - 1) ? 0 : r + 1;
            end else begin
                mCol = c + 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [OW-1:0] got;
        logic [OW-1:0] exp;
        got = {win_valid, win_last, win_row, win_col, err_line, err_frame, err_pad, win_data};
        exp = {mValid, mLast, mWr, mWc, mErrLine, mErrFrame, mErrPad, mData};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
        if (win_valid === 1'b1) begin
            winCount++;
            if (capture && win_row < 5'(NW) && win_col < 5'(NW)) begin
                capData[int'(win_row) * NW + int'(win_col)] = win_data;
                capLast[int'(win_row) * NW + int'(win_col)] = win_last;
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the current inputs, starting and ending on a falling edge.
    task automatic tick(input string tag);
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] pix, input logic lineLast,
                                 input logic frameLast, input logic isPad, input int gap);
        in_valid      = 1'b1;
        in_pixel      = pix;
        in_line_last  = lineLast;
        in_frame_last = frameLast;
        in_is_pad     = isPad;
        tick("pixel");
        in_valid      = 1'b0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
        in_is_pad     = 1'b0;
        repeat (gap) tick("idle");
    endtask

    task automatic sendRow(input int r, input int lastCol, input logic frameEnd,
                           input int gap, input int padFlipCol);
        for (int c = 0; c <= lastCol; c++) begin
            applyStimulus(rampPix(r, c), c == lastCol, frameEnd && (c == lastCol),
                          padOf(r) ^ (c == padFlipCol), gap);
        end
    endtask

    task automatic sendFrame(input int gap);
        for (int r = 0; r < H; r++) begin
            sendRow(r, W - 1, r == H - 1, gap, -1);
        end
    endtask

    // Raise reset away from any clock edge and confirm the outputs clear
    // before the next edge arrives.
    task automatic applyReset(input string tag);
        in_valid      = 1'b0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
        in_is_pad     = 1'b0;
        #2;
        srst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        srst = 1'b0;
    endtask

    initial begin
        srst          = 1'b0;
        in_valid      = 1'b0;
        in_pixel      = '0;
        in_line_last  = 1'b0;
        in_frame_last = 1'b0;
        in_is_pad     = 1'b0;
        capture       = 1'b0;
        winCount      = 0;
        for (int c = 0; c < W; c++) begin
            for (int e = 0; e < K; e++) begin
                colHist[c][e] = '0;
            end
        end
        modelReset();

        spots[0] = '{wr: 0,  wc: 0,  elem: 0,  data: 8'h00, last: 1'b0};
        spots[1] = '{wr: 0,  wc: 0,  elem: 24, data: 8'h84, last: 1'b0};
        spots[2] = '{wr: 27, wc: 27, elem: 24, data: 8'hFF, last: 1'b1};
        spots[3] = '{wr: 27, wc: 27, elem: 0,  data: 8'h7B, last: 1'b1};
        spots[4] = '{wr: 10, wc: 5,  elem: 13, data: 8'h88, last: 1'b0};
        spots[5] = '{wr: 3,  wc: 27, elem: 4,  data: 8'h7F, last: 1'b0};
        spots[6] = '{wr: 5,  wc: 0,  elem: 20, data: 8'h20, last: 1'b0};
        spots[7] = '{wr: 27, wc: 0,  elem: 24, data: 8'hE4, last: 1'b0};
        spots[8] = '{wr: 0,  wc: 27, elem: 20, data: 8'h9B, last: 1'b0};

        applyReset("reset state");

        $display("[TB] ramp frame, one pixel every 4 clocks");
        winCount = 0;
        capture  = 1'b1;
        sendFrame(3);
        capture  = 1'b0;
        checkValue("ramp window count", winCount, NWIN);
        checkValue("ramp error flags", {29'd0, err_line, err_frame, err_pad}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            checkValue($sformatf("spot data w(%0d,%0d) e%0d", spots[i].wr, spots[i].wc, spots[i].elem),
                       {24'd0, capData[spots[i].wr * NW + spots[i].wc][8*spots[i].elem +: 8]},
                       {24'd0, spots[i].data});
            checkValue($sformatf("spot last w(%0d,%0d)", spots[i].wr, spots[i].wc),
                       {31'd0, capLast[spots[i].wr * NW + spots[i].wc]}, {31'd0, spots[i].last});
        end

        $display("[TB] back-to-back frame");
        winCount = 0;
        sendFrame(0);
        checkValue("b2b window count", winCount, NWIN);

        $display("[TB] short line on row 6");
        applyReset("reset before short line");
        winCount = 0;
        for (int r = 0; r < 6; r++) sendRow(r, W - 1, 1'b0, 0, -1);
        sendRow(6, W - 2, 1'b0, 0, -1);
        checkValue("short line err_line", {31'd0, err_line}, 32'd1);
        for (int c = 0; c < 5; c++) applyStimulus(rampPix(7, c), 1'b0, 1'b0, padOf(7), 0);
        checkValue("resync win_row", {27'd0, win_row}, 32'd3);
        checkValue("resync win_col", {27'd0, win_col}, 32'd0);
        for (int c = 5; c < W; c++) applyStimulus(rampPix(7, c), c == W - 1, 1'b0, padOf(7), 0);
        for (int r = 8; r < H; r++) sendRow(r, W - 1, r == H - 1, 0, -1);
        checkValue("short line window count", winCount, NWIN - 1);
        checkValue("short line err_line sticky", {31'd0, err_line}, 32'd1);

        $display("[TB] pad flag mismatch on row 0");
        applyReset("reset before pad");
        winCount = 0;
        sendRow(0, W - 1, 1'b0, 0, 5);
        checkValue("pad mismatch err_pad", {31'd0, err_pad}, 32'd1);
        for (int r = 1; r < H; r++) sendRow(r, W - 1, r == H - 1, 0, -1);
        checkValue("pad frame window count", winCount, NWIN);
        checkValue("pad frame other errors", {30'd0, err_line, err_frame}, 32'd0);

        $display("[TB] early frame end at row 20");
        applyReset("reset before early end");
        for (int r = 0; r < 20; r++) sendRow(r, W - 1, 1'b0, 0, -1);
        sendRow(20, W - 1, 1'b1, 0, -1);
        checkValue("early end err_frame", {31'd0, err_frame}, 32'd1);
        winCount = 0;
        sendFrame(0);
        checkValue("after early end window count", winCount, NWIN);
        checkValue("early end err_frame sticky", {31'd0, err_frame}, 32'd1);

        $display("[TB] reset in the middle of row 10");
        for (int r = 0; r < 10; r++) sendRow(r, W - 1, 1'b0, 0, -1);
        for (int c = 0; c < 10; c++) applyStimulus(rampPix(10, c), 1'b0, 1'b0, padOf(10), 0);
        applyReset("mid-frame reset");
        winCount = 0;
        sendFrame(0);
        checkValue("after reset window count", winCount, NWIN);
        checkValue("after reset error flags", {29'd0, err_line, err_frame, err_pad}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_window5x5.md
# pad_window5x5

Consumer of the zero-padded pixel stream. It accepts the W x H padded frame one pixel per `in_valid` pulse and buffers the last K-1 lines. Each time a full KxK neighbourhood is available, it emits that neighbourhood as one flat window. It sits between the row zero-padder and the conv1 MAC array of the LeNet-5 pipeline, and it checks the incoming stream's framing.

## Interface
- `W`, 32: pixels per line
- `H`, 32: lines per padded frame, i.e. HIN + 2*PAD
- `K`, 5: window size
- `PAD`, 4: pad lines at the top and at the bottom
- `clk`  in  1  sole clock, rising edge
- `srst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  1-clk pixel strobe; may be back-to-back
- `in_pixel`  in  8  pixel value
- `in_line_last`  in  1  qualifies the last pixel of a line
- `in_frame_last`  in  1  qualifies the last pixel of a frame
- `in_is_pad`  in  1  pixel belongs to a pad line
- `win_valid`  out  1  1-clk window strobe
- `win_data`  out  8*K*K  window; element (r,c) at bits [8*(r*K+c)+7 : 8*(r*K+c)], r=0 is the top row and c=0 is the left column
- `win_row`  out  CLOG2(H)  output row index, 0..H-K
- `win_col`  out  CLOG2(W)  output column index, 0..W-K
- `win_last`  out  1  last window of the frame
- `err_line`  out  1  sticky line-length error
- `err_frame`  out  1  sticky frame-length error
- `err_pad`  out  1  sticky pad-flag error

## Operation
**Counters and buffering**
- Counters `col` (0..W-1) and `row` (0..H-1) advance only on `in_valid`. Cycles with `in_valid`=0 change no state.
- Line store holds the K-1 previous lines, W bytes each. On each accepted pixel at column `col`:
  - the K-1 stored bytes at `col` are read and the new pixel is appended as the bottom entry;
  - this K-deep column shifts into the KxK window register from the right;
  - the line store is updated at `col`.
- No window is emitted before row K-1 and column K-1, so the line store and window register need no reset.

**Window emission**
- A window is emitted on an accepted pixel when `row>=K-1` and `col>=K-1`.
- `win_row` = `row`-(K-1); `win_col` = `col`-(K-1).
- Element (r,c) = input pixel at (`row`-K+1+r, `col`-K+1+c).
- `win_last`=1 when `row`=H-1 and `col`=W-1.

**Line framing**
- If `col`=W-1 and `in_line_last`=1: `col` goes to 0 and `row` advances.
- If `in_line_last`=1 while `col`!=W-1: set `err_line`, `col` goes to 0, `row` advances (resync).
- If `col`=W-1 and `in_line_last`=0: set `err_line`; `col` still wraps to 0 and `row` advances.

**Frame framing**
- `in_frame_last`=1 always resets `row`/`col` to 0 after the pixel is processed.
- Set `err_frame` if `in_frame_last` arrives away from (H-1, W-1).
- Set `err_frame` if the pixel at (H-1, W-1) arrives without `in_frame_last`; `row` still wraps to 0.

**Pad check**
- `in_is_pad` must equal (`row`<PAD or `row`>=H-PAD); a mismatch on any accepted pixel sets `err_pad`.

**Error flags**
- Error flags clear only on `srst`. Windows are still emitted after an error, using the resynced counters.

## Timing
- Latency is 1 clk: `win_*` are registered and asserted the cycle after the qualifying `in_valid`.
- `win_valid` and `win_last` are single-cycle pulses. `win_data`, `win_row` and `win_col` hold between pulses.
- Sustained throughput is 1 window/clk with back-to-back `in_valid`.
- Error flags assert in the cycle after the offending pixel.
- On `srst` assertion, immediately (asynchronously):
  - `win_valid`, `win_last` and all `err_*` go to 0;
  - `win_data`, `win_row` and `win_col` go to 0;
  - `row` and `col` go to 0.
- If `srst` is asserted mid-frame, the next accepted pixel is treated as (0,0).
- No stalls or backpressure: the downstream block must accept every `win_valid`.
- Simultaneous `in_line_last` and `in_frame_last` at (H-1, W-1) is the normal end of frame, not an error.

## Structure
- The shared package/include holds:
  - the `CLOG2` function;
  - the LeNet input constants LENET_W=32, LENET_H=32, LENET_K=5 and LENET_PAD=4.
- Sub-module `line_store_k`: (K-1) x W x 8 column-addressed store with a read-before-write column port.
- Window register, counters and checks stay in the top level.

## Test plan
- **Ramp frame:** pixel=(row*32+col)&0xFF, pad flags correct, one pulse per 4 clk → 784 windows. First window: `win_row`=0, `win_col`=0, elem(0,0)=0x00, elem(4,4)=0x84. 784th window: `win_last`=1, `win_row`=27, `win_col`=27, elem(4,4)=0xFF. All `err_*`=0.
- **Back-to-back:** same frame with `in_valid` held high → 784 windows on consecutive cycles, each 1 clk after its pixel; identical data to the ramp frame.
- **Short line:** `in_line_last` at `col`=30 of row 6 → `err_line`=1. The next pixel is treated as row 7, col 0. No window is emitted for the missing column.
- **Pad mismatch:** `in_is_pad`=0 on row 0 → `err_pad`=1. Window output is unaffected.
- **Early frame end:** `in_frame_last` at row 20, col 31 → `err_frame`=1. The following valid frame yields 784 correct windows.
- **Reset mid-frame:** `srst` pulse at row 10 → all outputs 0 immediately. The following frame yields 784 correct windows with `err_*`=0.
